// File: rtl/bit_reverse_stream.sv
// Ping-pong reorder buffer: each N-sample frame is emitted bit-reversed, or in natural order when bypassed.
// Latency: first output is valid the cycle after the frame's last write. Backpressure: in_ready is low while both banks hold unread frames.
module bit_reverse_stream #(
  parameter int N      = 8,
  parameter int DATA_W = 16,
  parameter int LOG2N  = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic                in_last,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]    out_index,
  output logic                out_last,
  output logic                frame_err
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_FILLING  = 2'd1,
    S_FULL     = 2'd2,
    S_DRAINING = 2'd3
  } bank_state_e;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  bank_state_e         r_state [2];
  bank_state_e         w_state_nxt [2];
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [LOG2N-1:0]    r_wr_idx;
  logic [LOG2N-1:0]    r_rd_cnt;
  logic [1:0]          r_mode;
  logic                r_frame_err;
  logic [2*DATA_W-1:0] r_mem [2][N];

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_out_valid;
  logic [LOG2N-1:0]    w_addr;
  logic                w_frame_bad;

  function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

  // Gated by reset_n so the writer never looks ready while held in reset.
  assign in_ready    = reset_n && ((r_state[r_wr_bank] == S_EMPTY) || (r_state[r_wr_bank] == S_FILLING));
  assign w_out_valid = (r_state[r_rd_bank] == S_FULL) || (r_state[r_rd_bank] == S_DRAINING);
  assign w_wr_acc    = in_valid && in_ready;
  assign w_rd_acc    = w_out_valid && out_ready;
  assign w_addr      = r_mode[r_rd_bank] ? r_rd_cnt : f_bitrev(r_rd_cnt);
  assign w_frame_bad = w_wr_acc && (in_last != (r_wr_idx == LAST_IDX));

  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_mem[r_rd_bank][w_addr] : '0;
  assign out_index = w_out_valid ? w_addr : '0;
  assign out_last  = w_out_valid && (r_rd_cnt == LAST_IDX);
  assign frame_err = r_frame_err;

  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    for (int b = 0; b < 2; b++) begin
      if (w_wr_acc && (r_wr_bank == b[0])) begin
        w_state_nxt[b] = (r_wr_idx == LAST_IDX) ? S_FULL : S_FILLING;
      end
      if (w_rd_acc && (r_rd_bank == b[0])) begin
        w_state_nxt[b] = (r_rd_cnt == LAST_IDX) ? S_EMPTY : S_DRAINING;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state[0]  <= S_EMPTY;
      r_state[1]  <= S_EMPTY;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_rd_cnt    <= '0;
      r_mode      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      if (w_wr_acc) begin
        if (r_wr_idx == '0) begin
          r_mode[r_wr_bank] <= in_mode;
        end
        if (r_wr_idx == LAST_IDX) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_rd_acc) begin
        if (r_rd_cnt == LAST_IDX) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  // Sample storage carries no reset; bank state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_bank][r_wr_idx] <= in_data;
    end
  end

endmodule

// File: doc/bit_reverse_stream.md
Name: bit_reverse_stream

Overview:
- Streaming ping-pong reorder buffer for FFT frames.
- Accepts complex samples one per cycle in natural order and emits each N-sample frame in bit-reversed order, or in natural order in bypass mode.
- Two banks allow one frame to fill while the previous frame drains, giving full throughput.
- Sits between the serial FFT stage outputs and the downstream MIMO-OFDM processing, replacing the single-shot parallel reverser.

Parameters:
- N, 8: frame length in samples. Power of two, at least 2. LOG2N = $clog2(N).
- DATA_W, 16: width of each real/imag component. A sample is 2*DATA_W bits, {imag, real}.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  2*DATA_W  input complex sample, natural order
- in_last  in  1  producer's end-of-frame marker; checked only, never used for control
- in_mode  in  1  0 = bit-reverse, 1 = natural/bypass; sampled on the first sample of each frame
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts a sample
- out_data  out  2*DATA_W  reordered sample
- out_index  out  LOG2N  natural-order index of the sample on out_data
- out_last  out  1  high on the final sample of an output frame
- frame_err  out  1  sticky framing error

Behaviour:
- Reset state (reset_n low, asynchronous):
  - Both banks EMPTY; wr_bank = rd_bank = 0; wr_idx = rd_cnt = 0; frame_err = 0.
  - out_valid = 0, out_last = 0, out_data = 0, out_index = 0, in_ready = 0 while reset_n is low.
  - Storage arrays are not reset.
  - Reset mid-frame discards all partial and full frames.
- Bank state per bank: EMPTY -> FILLING on the first accepted write. FILLING -> FULL when sample N-1 is accepted. FULL -> DRAINING on the first accepted read. DRAINING -> EMPTY when sample N-1 is read. A FULL bank whose first read is accepted in the same cycle goes directly to DRAINING.
- Write side:
  - in_ready = state[wr_bank] is EMPTY or FILLING, decoded from registered state only. No combinational path from out_ready.
  - Accept = in_valid && in_ready. On accept: bank[wr_bank][wr_idx] <= in_data; wr_idx++.
  - On wr_idx == 0, latch in_mode into mode[wr_bank].
  - On wr_idx == N-1: wr_idx wraps to 0, wr_bank toggles, bank becomes FULL.
- Read side:
  - out_valid = state[rd_bank] is FULL or DRAINING.
  - addr = rd_cnt when mode[rd_bank] = 1; otherwise the LOG2N-bit reversal of rd_cnt.
  - out_data = bank[rd_bank][addr]; out_index = addr; out_last = out_valid && (rd_cnt == N-1).
  - Outputs are combinational reads of the registered array. When out_valid is 0, out_data, out_index and out_last are forced to 0.
  - On out_valid && out_ready: rd_cnt++. At N-1, rd_cnt wraps to 0, rd_bank toggles, bank becomes EMPTY.
  - out_data, out_index and out_last hold stable while out_valid && !out_ready.
- Latency:
  - Accept of sample N-1 at edge k: out_valid is high from edge k, so the first output is available in the cycle after the last write.
  - Sustained throughput with out_ready held high is 1 sample/cycle, with no bubbles between frames.
- Simultaneous events:
  - A bank's last read and the writer toggling onto that bank at the same edge: the bank is EMPTY after the edge and in_ready is high the next cycle.
  - A write to one bank and a read from the other bank in the same cycle are independent.
  - A write and a read never target the same bank in the same cycle, because a bank is only written when EMPTY or FILLING and only read when FULL or DRAINING.
- Backpressure: when both banks are FULL or DRAINING, in_ready = 0 until rd_bank drains.
- frame_err is set, and held until reset, on either condition:
  - an accepted sample has in_last = 1 with wr_idx != N-1;
  - an accepted sample has in_last = 0 with wr_idx == N-1.
  - Framing continues by count regardless of frame_err.

Test Plan:
- Reset then N=8, mode 0, in_data = index 0..7, in_last on sample 7, out_ready = 1 → out_data sequence 0,4,2,6,1,5,3,7; out_last on the 8th output; first out_valid in the cycle after sample 7 is accepted; frame_err = 0.
- Three back-to-back frames, in_valid = out_ready = 1 throughout → in_ready never drops after the first cycle; 24 outputs with no gaps; each frame reordered correctly.
- Frame A in mode 1, then frame B in mode 0 → A emits 0..7 in natural order, B emits the bit-reversed order; in_mode toggled mid-frame has no effect.
- out_ready = 0 while feeding 16 samples → in_ready falls after the 16th accept and out_data stays at index 0 of frame 1. Then raise out_ready: frame 1 drains, in_ready reasserts the cycle after its last read.
- in_last asserted on sample 3 → frame_err = 1 from the next edge and stays high; the frame still outputs 8 correctly reordered samples.
- reset_n pulsed low mid-drain (asynchronously, between clock edges) → out_valid and in_ready drop immediately; after release, a fresh frame reorders correctly with no residue from the old frame.
